alu_rs: RTL and testbench

Reservation station that buffers issued integer ALU operations, tracks their source operands by ROB tag, snoops the common data bus (CDB) for missing values, and schedules at most one ready entry per cycle onto the shared ALU. It sits between the issue stage and the ALU. Its registered dispatch outputs drive the ALU's `cal`, `a`, `b` and `alu_op` inputs directly. It forwards the destination ROB tag so the ALU result can be broadcast on the CDB.

---
 rtl/alu_rs_pkg.sv | 26 ++
 rtl/alu_rs_select.sv | 26 ++
 rtl/alu_rs.sv | 194 +++++++++++++++++++
 tb/tb_alu_rs.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station.
// Contents:
//   ROB_TAG_W - default ROB tag width
//   DATA_W    - operand width
//   OP_W      - ALU op-code width
//   alu_op_e  - ALU op codes understood by the downstream ALU
package alu_rs_pkg;

    localparam int ROB_TAG_W = 4;
    localparam int DATA_W    = 32;
    localparam int OP_W      = 4;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

endpackage

// File: rtl/alu_rs_select.sv
// Lowest-index priority encoder.
// Ports:
//   req   in  2**RS_WIDTH  request vector
//   found out 1            any request bit set
//   idx   out RS_WIDTH     index of the lowest set bit (0 when none)
module alu_rs_select #(
    parameter int RS_WIDTH = 3
) (
    input  logic [2**RS_WIDTH-1:0] req,
    output logic                   found,
    output logic [RS_WIDTH-1:0]    idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan from the top down so the lowest set bit is the last one written.
        for (int i = 2**RS_WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = RS_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for integer ALU operations.
// Buffers issued operations, tracks missing source operands by ROB tag,
// snoops the CDB for their values and dispatches the lowest-index ready
// entry to the ALU, at most one per cycle.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global enable), clear (flush)
//   issue_*  : one operation from the issue stage
//   cdb_*    : common data bus broadcast
//   full     : no free entry (combinational from busy bits)
//   cal, a, b, alu_op, alu_dest : registered dispatch to the ALU
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_WIDTH  = 3,
    parameter int ROB_WIDTH = ROB_TAG_W
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 issue_valid,
    input  logic [OP_W-1:0]      issue_op,
    input  logic                 issue_qj_busy,
    input  logic                 issue_qk_busy,
    input  logic [ROB_WIDTH-1:0] issue_qj,
    input  logic [ROB_WIDTH-1:0] issue_qk,
    input  logic [DATA_W-1:0]    issue_vj,
    input  logic [DATA_W-1:0]    issue_vk,
    input  logic [ROB_WIDTH-1:0] issue_dest,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_rob,
    input  logic [DATA_W-1:0]    cdb_value,
    output logic                 full,
    output logic                 cal,
    output logic [DATA_W-1:0]    a,
    output logic [DATA_W-1:0]    b,
    output logic [OP_W-1:0]      alu_op,
    output logic [ROB_WIDTH-1:0] alu_dest
);

    localparam int N = 2**RS_WIDTH;

    // Entry control state
    logic [N-1:0]         busy_q, busy_d;
    logic [N-1:0]         jb_q, jb_d;
    logic [N-1:0]         kb_q, kb_d;
    // Entry payload
    logic [OP_W-1:0]      op_q   [N];
    logic [OP_W-1:0]      op_d   [N];
    logic [DATA_W-1:0]    vj_q   [N];
    logic [DATA_W-1:0]    vj_d   [N];
    logic [DATA_W-1:0]    vk_q   [N];
    logic [DATA_W-1:0]    vk_d   [N];
    logic [ROB_WIDTH-1:0] qj_q   [N];
    logic [ROB_WIDTH-1:0] qj_d   [N];
    logic [ROB_WIDTH-1:0] qk_q   [N];
    logic [ROB_WIDTH-1:0] qk_d   [N];
    logic [ROB_WIDTH-1:0] dest_q [N];
    logic [ROB_WIDTH-1:0] dest_d [N];
    // Dispatch outputs
    logic                 cal_q, cal_d;
    logic [DATA_W-1:0]    a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]      aop_q, aop_d;
    logic [ROB_WIDTH-1:0] adest_q, adest_d;

    logic [N-1:0]         free_vec, ready_vec;
    logic                 free_found, rdy_found;
    logic [RS_WIDTH-1:0]  free_idx, rdy_idx;

    // Readiness uses registered state only, so a CDB capture becomes
    // eligible one cycle later.
    assign free_vec  = ~busy_q;
    assign ready_vec = busy_q & ~jb_q & ~kb_q;

    alu_rs_select #(.RS_WIDTH(RS_WIDTH)) u_free_sel (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    alu_rs_select #(.RS_WIDTH(RS_WIDTH)) u_ready_sel (
        .req   (ready_vec),
        .found (rdy_found),
        .idx   (rdy_idx)
    );

    assign full = ~free_found;

    always_comb begin
        busy_d  = busy_q;
        jb_d    = jb_q;
        kb_d    = kb_q;
        op_d    = op_q;
        vj_d    = vj_q;
        vk_d    = vk_q;
        qj_d    = qj_q;
        qk_d    = qk_q;
        dest_d  = dest_q;
        cal_d   = cal_q;
        a_d     = a_q;
        b_d     = b_q;
        aop_d   = aop_q;
        adest_d = adest_q;

        if (rdy_in) begin
            if (clear) begin
                busy_d = '0;
                cal_d  = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (cdb_valid && busy_q[i] && jb_q[i] && (qj_q[i] == cdb_rob)) begin
                        vj_d[i] = cdb_value;
                        jb_d[i] = 1'b0;
                    end
                    if (cdb_valid && busy_q[i] && kb_q[i] && (qk_q[i] == cdb_rob)) begin
                        vk_d[i] = cdb_value;
                        kb_d[i] = 1'b0;
                    end
                end

                cal_d = rdy_found;
                if (rdy_found) begin
                    a_d             = vj_q[rdy_idx];
                    b_d             = vk_q[rdy_idx];
                    aop_d           = op_q[rdy_idx];
                    adest_d         = dest_q[rdy_idx];
                    busy_d[rdy_idx] = 1'b0;
                end

                // The free slot is never the dispatched one, so both updates
                // can land on the same edge without interfering.
                if (issue_valid && free_found) begin
                    busy_d[free_idx] = 1'b1;
                    op_d[free_idx]   = issue_op;
                    dest_d[free_idx] = issue_dest;
                    qj_d[free_idx]   = issue_qj;
                    qk_d[free_idx]   = issue_qk;
                    jb_d[free_idx]   = issue_qj_busy;
                    kb_d[free_idx]   = issue_qk_busy;
                    vj_d[free_idx]   = issue_vj;
                    vk_d[free_idx]   = issue_vk;
                    // Producer broadcasting this very cycle: take the CDB value.
                    if (issue_qj_busy && cdb_valid && (cdb_rob == issue_qj)) begin
                        jb_d[free_idx] = 1'b0;
                        vj_d[free_idx] = cdb_value;
                    end
                    if (issue_qk_busy && cdb_valid && (cdb_rob == issue_qk)) begin
                        kb_d[free_idx] = 1'b0;
                        vk_d[free_idx] = cdb_value;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q  <= '0;
            jb_q    <= '0;
            kb_q    <= '0;
            cal_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            aop_q   <= '0;
            adest_q <= '0;
        end else begin
            busy_q  <= busy_d;
            jb_q    <= jb_d;
            kb_q    <= kb_d;
            cal_q   <= cal_d;
            a_q     <= a_d;
            b_q     <= b_d;
            aop_q   <= aop_d;
            adest_q <= adest_d;
        end
    end

    // Payload is qualified by busy, so it needs no reset.
    always_ff @(posedge clk_in) begin
        op_q   <= op_d;
        vj_q   <= vj_d;
        vk_q   <= vk_d;
        qj_q   <= qj_d;
        qk_q   <= qk_d;
        dest_q <= dest_d;
    end

    assign cal      = cal_q;
    assign a        = a_q;
    assign b        = b_q;
    assign alu_op   = aop_q;
    assign alu_dest = adest_q;

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int N = 8;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear, issue_valid;
    logic [3:0]  issue_op;
    logic        issue_qj_busy, issue_qk_busy;
    logic [3:0]  issue_qj, issue_qk, issue_dest;
    logic [31:0] issue_vj, issue_vk;
    logic        cdb_valid;
    logic [3:0]  cdb_rob;
    logic [31:0] cdb_value;
    logic        full, cal;
    logic [31:0] a, b;
    logic [3:0]  alu_op, alu_dest;

    alu_rs #(.RS_WIDTH(3), .ROB_WIDTH(4)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .clear         (clear),
        .issue_valid   (issue_valid),
        .issue_op      (issue_op),
        .issue_qj_busy (issue_qj_busy),
        .issue_qk_busy (issue_qk_busy),
        .issue_qj      (issue_qj),
        .issue_qk      (issue_qk),
        .issue_vj      (issue_vj),
        .issue_vk      (issue_vk),
        .issue_dest    (issue_dest),
        .cdb_valid     (cdb_valid),
        .cdb_rob       (cdb_rob),
        .cdb_value     (cdb_value),
        .full          (full),
        .cal           (cal),
        .a             (a),
        .b             (b),
        .alu_op        (alu_op),
        .alu_dest      (alu_dest)
    );

    always #5 clk_in = ~clk_in;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a table of waiting operations plus the last dispatch.
    typedef struct {
        bit        busy;
        bit [3:0]  op;
        bit [31:0] vj, vk;
        bit        jb, kb;
        bit [3:0]  qj, qk, dest;
    } ment_t;

    ment_t     m [N];
    bit        m_cal;
    bit [31:0] m_a, m_b;
    bit [3:0]  m_op, m_dest;

    function automatic bit m_full();
        for (int i = 0; i < N; i++)
            if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m[i].busy = 1'b0;
        m_cal = 1'b0; m_a = '0; m_b = '0; m_op = '0; m_dest = '0;
    endfunction

    // Advance the model by one clock edge using the current input values.
    function automatic void model_step();
        ment_t n [N];
        int fi, ri;
        if (rdy_in !== 1'b1) return;
        if (clear === 1'b1) begin
            for (int i = 0; i < N; i++) m[i].busy = 1'b0;
            m_cal = 1'b0;
            return;
        end
        fi = -1; ri = -1;
        for (int i = 0; i < N; i++) begin
            if (!m[i].busy && fi < 0) fi = i;
            if (m[i].busy && !m[i].jb && !m[i].kb && ri < 0) ri = i;
        end
        n = m;
        for (int i = 0; i < N; i++) begin
            if (m[i].busy && cdb_valid) begin
                if (m[i].jb && m[i].qj == cdb_rob) begin n[i].vj = cdb_value; n[i].jb = 1'b0; end
                if (m[i].kb && m[i].qk == cdb_rob) begin n[i].vk = cdb_value; n[i].kb = 1'b0; end
            end
        end
        if (ri >= 0) begin
            m_cal = 1'b1; m_a = m[ri].vj; m_b = m[ri].vk; m_op = m[ri].op; m_dest = m[ri].dest;
            n[ri].busy = 1'b0;
        end else begin
            m_cal = 1'b0;
        end
        if (issue_valid && fi >= 0) begin
            n[fi].busy = 1'b1; n[fi].op = issue_op; n[fi].dest = issue_dest;
            n[fi].qj = issue_qj; n[fi].qk = issue_qk;
            n[fi].jb = issue_qj_busy; n[fi].vj = issue_vj;
            n[fi].kb = issue_qk_busy; n[fi].vk = issue_vk;
            if (issue_qj_busy && cdb_valid && cdb_rob == issue_qj) begin n[fi].jb = 1'b0; n[fi].vj = cdb_value; end
            if (issue_qk_busy && cdb_valid && cdb_rob == issue_qk) begin n[fi].kb = 1'b0; n[fi].vk = cdb_value; end
        end
        m = n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("m_cal",  32'(cal),      32'(m_cal));
        check("m_full", 32'(full),     32'(m_full()));
        check("m_a",    a,             m_a);
        check("m_b",    b,             m_b);
        check("m_op",   32'(alu_op),   32'(m_op));
        check("m_dest", 32'(alu_dest), 32'(m_dest));
    endtask

    // One clock: model follows the same inputs, outputs compared after the edge,
    // then one-shot inputs return to idle.
    task automatic cycle();
        model_step();
        @(posedge clk_in);
        #1;
        check_model();
        issue_valid = 1'b0;
        cdb_valid   = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic set_issue(input logic [3:0] op, input logic jb, input logic [3:0] qj,
                             input logic [31:0] vj, input logic kb, input logic [3:0] qk,
                             input logic [31:0] vk, input logic [3:0] dest);
        issue_valid = 1'b1; issue_op = op;
        issue_qj_busy = jb; issue_qj = qj; issue_vj = vj;
        issue_qk_busy = kb; issue_qk = qk; issue_vk = vk;
        issue_dest = dest;
    endtask

    task automatic set_bcast(input logic [3:0] rob, input logic [31:0] val);
        cdb_valid = 1'b1; cdb_rob = rob; cdb_value = val;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; issue_valid = 1'b0;
        issue_op = '0; issue_qj_busy = 1'b0; issue_qk_busy = 1'b0;
        issue_qj = '0; issue_qk = '0; issue_vj = '0; issue_vk = '0; issue_dest = '0;
        cdb_valid = 1'b0; cdb_rob = '0; cdb_value = '0;
        model_reset();
        #12;
        rst_in = 1'b0;

        // Reset state
        check("rst_cal",  32'(cal),  32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_a",    a,         32'd0);
        check("rst_dest", 32'(alu_dest), 32'd0);

        // Direct dispatch
        set_issue(ALU_ADD, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7, 4'd3);
        cycle();
        check("dd_cal_issue_edge", 32'(cal), 32'd0);
        cycle();
        check("dd_cal",  32'(cal),      32'd1);
        check("dd_a",    a,             32'd5);
        check("dd_b",    b,             32'd7);
        check("dd_op",   32'(alu_op),   32'd0);
        check("dd_dest", 32'(alu_dest), 32'd3);
        cycle();
        check("dd_cal_after", 32'(cal), 32'd0);

        // Wakeup through the CDB
        set_issue(ALU_SUB, 1'b1, 4'd6, 32'd0, 1'b0, 4'd0, 32'd1, 4'd4);
        cycle();
        cycle();
        check("wk_wait1", 32'(cal), 32'd0);
        set_bcast(4'd6, 32'd10);
        cycle();
        check("wk_bcast_edge", 32'(cal), 32'd0);
        cycle();
        check("wk_cal", 32'(cal),    32'd1);
        check("wk_a",   a,           32'd10);
        check("wk_b",   b,           32'd1);
        check("wk_op",  32'(alu_op), 32'd1);

        // Issue-time bypass
        set_issue(ALU_AND, 1'b0, 4'd0, 32'd3, 1'b1, 4'd2, 32'd0, 4'd5);
        set_bcast(4'd2, 32'hFFFF_FFFF);
        cycle();
        cycle();
        check("byp_cal", 32'(cal), 32'd1);
        check("byp_b",   b,        32'hFFFF_FFFF);

        // Fill all entries waiting on tag 9, then release them
        for (int i = 0; i < N; i++) begin
            set_issue(ALU_OR, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'(i), 4'(i));
            cycle();
            if (i == N - 2) check("full_at7", 32'(full), 32'd0);
        end
        check("full_at8", 32'(full), 32'd1);
        set_issue(ALU_XOR, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2, 4'd15);
        cycle();
        check("full_ignored_full", 32'(full), 32'd1);
        check("full_ignored_cal",  32'(cal),  32'd0);
        set_bcast(4'd9, 32'h1234_0000);
        cycle();
        check("order_capture_edge", 32'(cal), 32'd0);
        for (int i = 0; i < N; i++) begin
            cycle();
            check("order_cal",  32'(cal),      32'd1);
            check("order_dest", 32'(alu_dest), 32'(i));
            check("order_a",    a,             32'h1234_0000);
            if (i == 0) check("order_full_fall", 32'(full), 32'd0);
        end
        cycle();
        check("order_drained", 32'(cal), 32'd0);

        // Clear mid-operation
        set_issue(ALU_ADD, 1'b1, 4'd11, 32'd0, 1'b0, 4'd0, 32'd0, 4'd1); cycle();
        set_issue(ALU_ADD, 1'b0, 4'd0, 32'd0, 1'b1, 4'd12, 32'd0, 4'd2); cycle();
        set_issue(ALU_ADD, 1'b1, 4'd13, 32'd0, 1'b1, 4'd13, 32'd0, 4'd3); cycle();
        set_issue(ALU_SLL, 1'b0, 4'd0, 32'd8, 1'b0, 4'd0, 32'd2, 4'd4); cycle();
        cycle();
        check("clr_pre_cal",  32'(cal),      32'd1);
        check("clr_pre_dest", 32'(alu_dest), 32'd4);
        clear = 1'b1;
        set_bcast(4'd11, 32'd77);
        set_issue(ALU_ADD, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1, 4'd8);
        cycle();
        check("clr_cal",  32'(cal),  32'd0);
        check("clr_full", 32'(full), 32'd0);
        set_bcast(4'd12, 32'd1); cycle();
        set_bcast(4'd13, 32'd2); cycle();
        set_bcast(4'd11, 32'd3); cycle();
        cycle();
        check("clr_no_dispatch", 32'(cal), 32'd0);

        // Stall with rdy_in low
        set_issue(ALU_XOR, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'h22, 4'd7);
        cycle();
        rdy_in = 1'b0;
        set_issue(ALU_ADD, 1'b0, 4'd0, 32'h99, 1'b0, 4'd0, 32'h99, 4'd9);
        set_bcast(4'd1, 32'h5);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_cal", 32'(cal), 32'd0);
        end
        rdy_in = 1'b1;
        cycle();
        check("stall_resume_cal",  32'(cal),      32'd1);
        check("stall_resume_a",    a,             32'h11);
        check("stall_resume_dest", 32'(alu_dest), 32'd7);
        rdy_in = 1'b0;
        cycle();
        cycle();
        check("stall_hold_cal", 32'(cal), 32'd1);
        rdy_in = 1'b1;
        cycle();
        check("stall_issue_dropped", 32'(cal), 32'd0);

        // Asynchronous reset between edges
        for (int i = 0; i < N - 1; i++) begin
            set_issue(ALU_ADD, 1'b1, 4'd14, 32'd0, 1'b0, 4'd0, 32'd0, 4'(i));
            cycle();
        end
        set_issue(ALU_SRA, 1'b0, 4'd0, 32'hABCD, 1'b0, 4'd0, 32'd4, 4'd5);
        cycle();
        cycle();
        check("ar_pre_a", a, 32'hABCD);
        set_issue(ALU_ADD, 1'b1, 4'd14, 32'd0, 1'b0, 4'd0, 32'd0, 4'd7);
        cycle();
        check("ar_pre_full", 32'(full), 32'd1);
        #2;
        rst_in = 1'b1;
        #1;
        check("ar_cal",  32'(cal),  32'd0);
        check("ar_a",    a,         32'd0);
        check("ar_full", 32'(full), 32'd0);
        #1;
        rst_in = 1'b0;
        model_reset();
        cycle();

        // Randomized traffic against the model
        for (int t = 0; t < 400; t++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) < 6)
                set_issue(4'($urandom_range(0, 9)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom,
                          4'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1)
                set_bcast(4'($urandom_range(0, 7)), $urandom);
            cycle();
        end
        rdy_in = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
